// File: rtl/shift_unloader_pkg.sv
// Shared constants for the parallel-to-serial unloader: state encoding and
// the word-index width helper.
package shift_unloader_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/shift_unloader.sv
// Captures one m*n-bit vector and streams it out as m n-bit words, LSB word
// first, so a downstream shift-in register rebuilds the vector bit-exact.
module shift_unloader
    import shift_unloader_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_valid,
    input  logic [m*n-1:0] x,
    output logic           x_ready,
    input  logic           flush,
    output logic [n-1:0]   y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           y_last,
    output logic           busy
);

    localparam int CW = idx_width(m);
    localparam logic [CW-1:0] IDX_LAST = CW'(m - 1);

    state_e         state_q, state_d;
    logic [m*n-1:0] hold_q, hold_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           send_s;
    logic           last_s;

    assign send_s = (state_q == ST_SEND);
    assign last_s = send_s && (idx_q == IDX_LAST);

    // State, shift register and word index, cleared asynchronously on rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: flush wins, then load, then word advance or end of vector.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            idx_d   = '0;
        end else if (x_valid && x_ready) begin
            state_d = ST_SEND;
            hold_d  = x;
            idx_d   = '0;
        end else if (send_s && y_ready) begin
            if (last_s) begin
                state_d = ST_IDLE;
                hold_d  = '0;
                idx_d   = '0;
            end else begin
                state_d = ST_SEND;
                hold_d  = hold_q >> n;
                idx_d   = idx_q + CW'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // Outputs decode directly from the registers; x_ready also admits a
    // reload on the accepted last word so vectors run back-to-back.
    always_comb begin
        y       = hold_q[n-1:0];
        y_valid = send_s;
        busy    = send_s;
        y_last  = last_s;
        x_ready = !send_s || (y_ready && last_s && !flush);
    end

endmodule

// File: tb/tb_shift_unloader.sv
// Directed and randomized bench for shift_unloader (m=4, n=8) against a
// word-queue reference model that also reassembles each vector at the sink.
module tb_shift_unloader;

    localparam int M = 4;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           x_valid;
    logic [M*N-1:0] x;
    logic           x_ready;
    logic           flush;
    logic [N-1:0]   y;
    logic           y_valid;
    logic           y_ready;
    logic           y_last;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int loaded   = 0;

    logic [N-1:0]   q_words[$];
    logic [N-1:0]   rx_words[$];
    logic [M*N-1:0] cur_vec[$];

    shift_unloader #(.m(M), .n(N)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .x_ready(x_ready),
        .flush(flush), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .y_last(y_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_words.delete();
        rx_words.delete();
        cur_vec.delete();
    endtask

    // One clock: compare outputs with the model, advance the model, clock.
    task automatic cyc();
        logic           mready;
        logic [M*N-1:0] asm_v;
        #1;
        mready = (q_words.size() == 0) || (y_ready && q_words.size() == 1 && !flush);
        chk("x_ready", {31'd0, x_ready}, {31'd0, mready});
        chk("y_valid", {31'd0, y_valid}, {31'd0, q_words.size() != 0});
        chk("busy", {31'd0, busy}, {31'd0, q_words.size() != 0});
        if (q_words.size() != 0) begin
            chk("y", {24'd0, y}, {24'd0, q_words[0]});
            chk("y_last", {31'd0, y_last}, {31'd0, q_words.size() == 1});
        end else begin
            chk("y_idle", {24'd0, y}, 32'd0);
            chk("y_last_idle", {31'd0, y_last}, 32'd0);
        end
        if (q_words.size() != 0 && y_ready) begin
            rx_words.push_back(q_words.pop_front());
            if (q_words.size() == 0) begin
                asm_v = '0;
                for (int i = 0; i < M; i++) asm_v[i*N +: N] = rx_words[i];
                chk("loopback", asm_v, cur_vec.pop_front());
                rx_words.delete();
            end
        end
        if (flush) begin
            model_clear();
        end else if (x_valid && mready) begin
            for (int i = 0; i < M; i++) q_words.push_back(x[i*N +: N]);
            cur_vec.push_back(x);
            loaded++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_b[4];
        logic [7:0] exp_f[4];
        int budget;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_f = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
        rst = 1'b0; x_valid = 1'b0; x = '0; y_ready = 1'b0; flush = 1'b0;

        // Reset state, and x_valid ignored while in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk("rst_y_last", {31'd0, y_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
        x_valid = 1'b1; x = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("rst_ignore_x", {31'd0, y_valid}, 32'd0);
        x_valid = 1'b0;
        rst = 1'b1;
        cyc();

        // Basic order.
        x = 32'h4433_2211; x_valid = 1'b1; y_ready = 1'b1;
        cyc();
        x_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("basic_word", {24'd0, y}, {24'd0, exp_b[k]});
            cyc();
        end
        chk("basic_done_xr", {31'd0, x_ready}, 32'd1);
        cyc();

        // Backpressure on word 22.
        x = 32'h4433_2211; x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
        cyc();
        y_ready = 1'b0;
        repeat (3) begin
            chk("bp_hold_y", {24'd0, y}, 32'h22);
            chk("bp_hold_last", {31'd0, y_last}, 32'd0);
            cyc();
        end
        y_ready = 1'b1;
        repeat (3) cyc();

        // Back-to-back vectors with no bubble.
        x = 32'h4433_2211; x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
        repeat (3) cyc();
        chk("b2b_w44", {24'd0, y}, 32'h44);
        x = 32'hDDCC_BBAA; x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
        chk("b2b_wAA", {24'd0, y}, 32'hAA);
        chk("b2b_valid", {31'd0, y_valid}, 32'd1);
        repeat (4) cyc();

        // Flush at word 22, then a fresh load.
        x = 32'h4433_2211; x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
        cyc();
        chk("flush_at22", {24'd0, y}, 32'h22);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_hold", dut.hold_q, 32'd0);
        x = 32'h0A0B_0C0D; x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("flush_reload", {24'd0, y}, {24'd0, exp_f[k]});
            cyc();
        end

        // Asynchronous reset during word 33.
        x = 32'h4433_2211; x_valid = 1'b1;
        cyc();
        x_valid = 1'b0;
        repeat (2) cyc();
        chk("arst_at33", {24'd0, y}, 32'h33);
        #2 rst = 1'b0;
        #1;
        chk("arst_y_valid", {31'd0, y_valid}, 32'd0);
        chk("arst_y_last", {31'd0, y_last}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_y", {24'd0, y}, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc();
        chk("arst_rel_xr", {31'd0, x_ready}, 32'd1);

        // Randomized loopback: 100 vectors, random ready, rare flush.
        loaded = 0;
        budget = 0;
        while (loaded < 100 && budget < 5000) begin
            x_valid = 1'($urandom_range(0, 1));
            x       = $urandom;
            y_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 63) == 0);
            cyc();
            budget++;
        end
        chk("rand_budget", {31'd0, loaded >= 100}, 32'd1);
        x_valid = 1'b0; flush = 1'b0; y_ready = 1'b1;
        repeat (M + 1) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
